// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    localparam logic [31:0] I_MEM_MSB  = 32'h0000_3FFF;
    localparam logic [31:0] D_MEM_BASE = I_MEM_MSB + 32'd1;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } t_load_type;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } t_store_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } t_dmem_state;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extract/extend and store byte-enable/replication.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] ld_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[8*lane +: 8];
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

        // Unrecognised load encodings fall back to a full-word read.
        ld_data = rd_word;
        case (funct3)
            LB:      ld_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     ld_data = {24'd0, byte_sel};
            LH:      ld_data = {{16{half_sel[15]}}, half_sel};
            LHU:     ld_data = {16'd0, half_sel};
            default: ld_data = rd_word;
        endcase

        // Unrecognised store encodings enable no bytes, so nothing is written.
        byte_en = 4'b0000;
        wr_word = wr_data;
        case (funct3)
            SB: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{wr_data[7:0]}};
            end
            SH: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wr_data[15:0]}};
            end
            SW: begin
                byte_en = 4'b1111;
                wr_word = wr_data;
            end
            default: begin
                byte_en = 4'b0000;
                wr_word = wr_data;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: fixed-latency single-outstanding access.
// Define DMEM_ERR_CHECK_EN to enable address-window, alignment and funct3 error responses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int D_MEM_WORDS = 4096,
    parameter int RSP_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrEn,
    input  logic [31:0] ReqAddr,
    input  logic [2:0]  ReqFunct3,
    input  logic [31:0] ReqWrData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspRdData,
    output logic        RspErr,
    output t_dmem_state dbg_state
);

    localparam int IDX_W = $clog2(D_MEM_WORDS);
    localparam logic [31:0] D_MEM_END = D_MEM_BASE + 32'(4 * D_MEM_WORDS);

    logic [31:0] mem [D_MEM_WORDS];

    t_dmem_state state, next_state;
    logic [1:0]  cnt;
    logic        wr_en_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wr_data_q;

    logic             accept, access;
    logic             acc_wr_en;
    logic [31:0]      acc_addr, acc_wr_data, offset;
    logic [2:0]       acc_funct3;
    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic [31:0]      ld_data, wr_word;
    logic [3:0]       byte_en;

    assign ReqReady  = (state == IDLE) && !Rst;
    assign RspValid  = (state == RESP);
    assign dbg_state = state;
    assign accept    = ReqValid && ReqReady;

    // With single-cycle latency the access happens on the accept edge, so the
    // operands come straight from the request rather than the latched copy.
    assign access      = ((state == BUSY) && (cnt == 2'd0)) ||
                         ((RSP_LATENCY == 1) && accept);
    assign acc_wr_en   = (RSP_LATENCY == 1) ? ReqWrEn   : wr_en_q;
    assign acc_addr    = (RSP_LATENCY == 1) ? ReqAddr   : addr_q;
    assign acc_funct3  = (RSP_LATENCY == 1) ? ReqFunct3 : funct3_q;
    assign acc_wr_data = (RSP_LATENCY == 1) ? ReqWrData : wr_data_q;

    // Truncating the offset gives the modulo wrap when error checking is off.
    assign offset = acc_addr - D_MEM_BASE;
    assign idx    = offset[IDX_W+1:2];

    always_comb begin
        acc_err = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        if ((acc_addr < D_MEM_BASE) || (acc_addr >= D_MEM_END))
            acc_err = 1'b1;
        if ((acc_funct3[1:0] == 2'b01) && acc_addr[0])
            acc_err = 1'b1;
        if ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00))
            acc_err = 1'b1;
        if (acc_wr_en && (acc_funct3 > 3'd2))
            acc_err = 1'b1;
        if (!acc_wr_en && ((acc_funct3 == 3'd3) || (acc_funct3 == 3'd6) || (acc_funct3 == 3'd7)))
            acc_err = 1'b1;
`else
        acc_err = 1'b0;
`endif
    end

    dmem_lane_align u_lane_align (
        .funct3  (acc_funct3),
        .lane    (acc_addr[1:0]),
        .rd_word (mem[idx]),
        .wr_data (acc_wr_data),
        .ld_data (ld_data),
        .byte_en (byte_en),
        .wr_word (wr_word)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (RSP_LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (cnt == 2'd0) next_state = RESP;
            RESP:    if (RspReady) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            wr_en_q   <= 1'b0;
            addr_q    <= 32'd0;
            funct3_q  <= 3'd0;
            wr_data_q <= 32'd0;
            RspRdData <= 32'd0;
            RspErr    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                wr_en_q   <= ReqWrEn;
                addr_q    <= ReqAddr;
                funct3_q  <= ReqFunct3;
                wr_data_q <= ReqWrData;
                cnt       <= 2'(RSP_LATENCY - 1);
            end else if ((state == BUSY) && (cnt != 2'd0)) begin
                cnt <= cnt - 2'd1;
            end
            if (access) begin
                RspRdData <= (acc_wr_en || acc_err) ? 32'd0 : ld_data;
                RspErr    <= acc_err;
            end
        end
    end

    // Memory is deliberately left out of reset; Rst only blocks a pending write.
    always_ff @(posedge Clk) begin
        if (!Rst && access && acc_wr_en && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32I core's load/store port; the core is the initiator, this block is the responder.
- Accepts one request via valid/ready, performs LB/LH/LW/LBU/LHU/SB/SH/SW on an internal word array, and returns a response after a fixed latency.
- Holds the response under backpressure.
- Covers the data region directly above instruction memory: byte addresses 'h4000..'h7FFF.

Parameters:
- D_MEM_BASE, 'h4000: first byte address of the data region (equals I_MEM_MSB+1).
- D_MEM_WORDS, 4096: number of 32-bit words ((D_MEM_MSB+1-D_MEM_BASE)/4).
- RSP_LATENCY, 2: cycles from accept edge to RspValid rising; legal range 1..4.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  responder can accept; high only in IDLE and low while Rst.
- ReqWrEn  in  1  1 = store, 0 = load.
- ReqAddr  in  32  byte address.
- ReqFunct3  in  3  instruction funct3 (size/sign).
- ReqWrData  in  32  store data, LSB-aligned.
- RspValid  out  1  response present.
- RspReady  in  1  initiator accepts response.
- RspRdData  out  32  load result, extended; 0 for stores and errors.
- RspErr  out  1  request rejected.

Behaviour:
- Reset (Rst high at an edge): state IDLE, RspValid=0, RspRdData=0, RspErr=0, latency counter=0. Memory contents are not cleared. Rst has priority over every other event.
- FSM states IDLE, BUSY, RESP:
  - IDLE: ReqReady=1. ReqValid&&ReqReady at an edge latches WrEn/Addr/Funct3/WrData, loads counter=RSP_LATENCY-1, and moves to BUSY. If RSP_LATENCY=1, moves straight to RESP at that edge (access performed at that edge).
  - BUSY: ReqReady=0. Counter decrements each edge. On the edge where counter==0, the memory access is performed and the state moves to RESP.
  - RESP: RspValid=1; RspRdData and RspErr stable. On RspValid&&RspReady at an edge, moves to IDLE and clears RspValid.
- Latency and throughput: request accepted at edge N gives RspValid high after edge N+RSP_LATENCY. One outstanding request; no back-to-back acceptance. Minimum period is RSP_LATENCY+1 cycles.
- Word index: (ReqAddr-D_MEM_BASE)>>2. Lane: ReqAddr[1:0].
- Loads:
  - LB(0)/LBU(4): byte at lane, sign- or zero-extended.
  - LH(1)/LHU(5): halfword at lane[1], sign- or zero-extended.
  - LW(2): full word.
- Stores:
  - SB(0): WrData[7:0] written to the selected byte; other bytes preserved.
  - SH(1): WrData[15:0] written to the selected halfword.
  - SW(2): full word.
  - Response has RspRdData=0, RspErr=0.
- Error cases (checked at access edge): address outside [D_MEM_BASE, D_MEM_BASE+4*D_MEM_WORDS); halfword with Addr[0]=1; word with Addr[1:0]!=0; load funct3 3/6/7; store funct3 >2.
  - An error produces no write, RspRdData=0, RspErr=1.
  - The address window check uses full 32-bit unsigned compare.
- Reset mid-operation: a transaction in BUSY is dropped. A store whose access edge coincides with Rst is not written. No response is issued after reset.
- ReqValid during BUSY/RESP is ignored; ReqReady stays 0.

Optional Feature:
- DMEM_ERR_CHECK_EN defined: error checks as above.
- Not defined:
  - RspErr tied 0.
  - Word index = ((ReqAddr-D_MEM_BASE)>>2) modulo D_MEM_WORDS.
  - Misaligned halfword uses lane {Addr[1],0*}; misaligned word ignores Addr[1:0].
  - Invalid funct3 loads behave as LW; invalid funct3 stores perform no write.

Decomposition:
- param_pkg additions: t_load_type enum (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101); t_store_type enum (SB, SH, SW); t_dmem_state enum (IDLE, BUSY, RESP); constant D_MEM_BASE = I_MEM_MSB+1.
- Sub-module dmem_lane_align (combinational):
  - Load path: lane extract and sign/zero extend.
  - Store path: 4-bit byte-enable and replicated write data.
  - Instantiated once.

Test Plan:
- SW 'h4000 data 'hDEADBEEF, then LW 'h4000 -> RspRdData='hDEADBEEF, RspErr=0. RspValid rises exactly 2 cycles after each accept; ReqReady=0 throughout BUSY/RESP.
- Word 'h4004='h11223344, then SB 'h4005 data 'h000000F0:
  - LW 'h4004 -> 'h1122F044.
  - LB 'h4005 -> 'hFFFFFFF0.
  - LBU 'h4005 -> 'h000000F0.
  - LHU 'h4006 -> 'h00001122.
- With DMEM_ERR_CHECK_EN:
  - LH 'h4003 -> RspErr=1, RspRdData=0.
  - SW 'h3FFC -> RspErr=1.
  - SW 'h8000 -> RspErr=1.
  - Load funct3=3 at 'h4000 -> RspErr=1.
  - LW 'h4000 afterwards returns the unchanged 'hDEADBEEF.
- Backpressure: hold RspReady=0 for 5 cycles during an LW -> RspValid/RspRdData stable; ReqValid pulses ignored. RspReady=1 -> IDLE next edge.
- Store SW 'h4010 'hCAFEF00D, assert Rst for 1 cycle in BUSY -> no RspValid; subsequent LW 'h4010 returns the prior value (0 after preload of 0).
- Without DMEM_ERR_CHECK_EN: LW 'h4002 -> returns word at 'h4000, RspErr=0. LW 'h8000 -> wraps to word at 'h4000.
